// File: rtl/catena_power_boot_sequencer_if.sv
// Signal bundle between the power/boot sequencer and the board: the PLL lock, the core's
// boot and shutdown requests, and the rail, reset and SB_WARMBOOT controls.
interface catena_power_boot_sequencer_if #(
    parameter int N_RAILS = 2
);
    // There is no valid/ready pairing here. boot_req is a one-cycle strobe that is taken
    // only in RUN; shutdown_req and pll_lock are levels sampled on every edge; all outputs are registered.
    logic               pll_lock;
    logic               boot_req;
    logic [1:0]         boot_image;
    logic               shutdown_req;
    logic [N_RAILS-1:0] rail_en;
    logic               core_reset;
    logic               wb_s1;
    logic               wb_s0;
    logic               wb_boot;
    logic               busy;
    logic [2:0]         state_dbg;

    modport master (
        output pll_lock, boot_req, boot_image, shutdown_req,
        input  rail_en, core_reset, wb_s1, wb_s0, wb_boot, busy, state_dbg
    );

    modport slave (
        input  pll_lock, boot_req, boot_image, shutdown_req,
        output rail_en, core_reset, wb_s1, wb_s0, wb_boot, busy, state_dbg
    );
endinterface

// File: rtl/catena_power_boot_sequencer.sv
// Sequences the power rails from the qualified PLL lock, releases the bootloader core from reset,
// and performs a delayed, glitch-free warmboot. All outputs are registered.
module catena_power_boot_sequencer #(
    parameter int N_RAILS     = 2,
    parameter int RAIL_DELAY  = 48000,
    parameter int LOCK_CYCLES = 4800,
    parameter int BOOT_DELAY  = 480000
) (
    input  logic                          i_clk_48mhz,
    input  logic                          i_reset,
    catena_power_boot_sequencer_if.slave  io_bus
);
    localparam int MAX_A = (RAIL_DELAY > LOCK_CYCLES) ? RAIL_DELAY : LOCK_CYCLES;
    localparam int MAX_D = (MAX_A > BOOT_DELAY) ? MAX_A : BOOT_DELAY;
    localparam int CW    = $clog2(MAX_D + 1);
    localparam int IW    = $clog2(N_RAILS + 1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_RUN       = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_BOOT_WAIT = 3'd4,
        S_BOOT      = 3'd5,
        S_OFF       = 3'd6
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [IW-1:0]      r_idx, w_idx_nxt;
    logic               r_off_pending, w_off_nxt;
    logic [1:0]         r_image, w_image_nxt;
    logic [N_RAILS-1:0] r_rail_en, w_rail_nxt;
    logic               r_core_reset, w_core_reset_nxt;
    logic               r_wb_s1, w_wb_s1_nxt;
    logic               r_wb_s0, w_wb_s0_nxt;
    logic               r_wb_boot, w_wb_boot_nxt;
    logic               r_busy;

    logic w_lock_done, w_dly_done, w_boot_done, w_last_rail, w_drop;

    // One shared counter serves lock qualification, rail spacing and the boot delay.
    assign w_lock_done = (r_cnt == CW'(LOCK_CYCLES - 1));
    assign w_dly_done  = (r_cnt == CW'(RAIL_DELAY - 1));
    assign w_boot_done = (r_cnt == CW'(BOOT_DELAY - 1));
    assign w_last_rail = (r_idx == IW'(N_RAILS - 1));
    assign w_drop      = !io_bus.pll_lock || io_bus.shutdown_req;

    always_ff @(posedge i_clk_48mhz) begin
        if (i_reset) begin
            r_state       <= S_WAIT_LOCK;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_off_pending <= 1'b0;
            r_image       <= 2'b00;
            r_rail_en     <= '0;
            r_core_reset  <= 1'b1;
            r_wb_s1       <= 1'b0;
            r_wb_s0       <= 1'b0;
            r_wb_boot     <= 1'b0;
            r_busy        <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_off_pending <= w_off_nxt;
            r_image       <= w_image_nxt;
            r_rail_en     <= w_rail_nxt;
            r_core_reset  <= w_core_reset_nxt;
            r_wb_s1       <= w_wb_s1_nxt;
            r_wb_s0       <= w_wb_s0_nxt;
            r_wb_boot     <= w_wb_boot_nxt;
            r_busy        <= (w_state_nxt != S_RUN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_LOCK: if (io_bus.pll_lock && w_lock_done) w_state_nxt = S_RAMP_UP;
            S_RAMP_UP: begin
                if (w_drop)                         w_state_nxt = S_RAMP_DOWN;
                else if (w_dly_done && w_last_rail) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_drop)                 w_state_nxt = S_RAMP_DOWN;
                else if (io_bus.boot_req)   w_state_nxt = S_BOOT_WAIT;
            end
            S_BOOT_WAIT: begin
                if (!io_bus.pll_lock) w_state_nxt = S_RAMP_DOWN;
                else if (w_boot_done) w_state_nxt = S_BOOT;
            end
            S_RAMP_DOWN: begin
                if (w_dly_done && (r_idx <= IW'(1)))
                    w_state_nxt = r_off_pending ? S_OFF : S_WAIT_LOCK;
            end
            S_BOOT:  w_state_nxt = S_BOOT;
            S_OFF:   w_state_nxt = S_OFF;
            default: w_state_nxt = S_WAIT_LOCK;
        endcase
    end

    always_comb begin
        w_cnt_nxt        = r_cnt;
        w_idx_nxt        = r_idx;
        w_off_nxt        = r_off_pending;
        w_image_nxt      = r_image;
        w_rail_nxt       = r_rail_en;
        w_core_reset_nxt = r_core_reset;
        w_wb_s1_nxt      = r_wb_s1;
        w_wb_s0_nxt      = r_wb_s0;
        w_wb_boot_nxt    = r_wb_boot;
        case (r_state)
            S_WAIT_LOCK: begin
                w_cnt_nxt = io_bus.pll_lock ? r_cnt + 1'b1 : '0;
                w_idx_nxt = '0;
            end
            S_RAMP_UP: begin
                w_cnt_nxt = r_cnt + 1'b1;
                // A shutdown seen together with lock loss still powers off for good.
                if (w_drop) begin
                    w_off_nxt = io_bus.shutdown_req;
                end else if (w_dly_done) begin
                    for (int k = 0; k < N_RAILS; k++)
                        if (IW'(k) == r_idx) w_rail_nxt[k] = 1'b1;
                    w_idx_nxt = r_idx + 1'b1;
                    w_cnt_nxt = '0;
                    if (w_last_rail) w_core_reset_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (w_drop) begin
                    w_core_reset_nxt = 1'b1;
                    w_off_nxt        = io_bus.shutdown_req;
                end else if (io_bus.boot_req) begin
                    w_image_nxt = io_bus.boot_image;
                end
            end
            S_BOOT_WAIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (!io_bus.pll_lock) begin
                    w_core_reset_nxt = 1'b1;
                end else if (w_boot_done) begin
                    w_wb_s1_nxt = r_image[1];
                    w_wb_s0_nxt = r_image[0];
                end
            end
            S_BOOT: w_wb_boot_nxt = 1'b1;
            S_RAMP_DOWN: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_dly_done) begin
                    for (int k = 0; k < N_RAILS; k++)
                        if (IW'(k + 1) == r_idx) w_rail_nxt[k] = 1'b0;
                    if (r_idx != '0) w_idx_nxt = r_idx - 1'b1;
                    w_cnt_nxt = '0;
                end
            end
            S_OFF: begin
                w_rail_nxt       = '0;
                w_core_reset_nxt = 1'b1;
            end
            default: ;
        endcase
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    assign io_bus.rail_en    = r_rail_en;
    assign io_bus.core_reset = r_core_reset;
    assign io_bus.wb_s1      = r_wb_s1;
    assign io_bus.wb_s0      = r_wb_s0;
    assign io_bus.wb_boot    = r_wb_boot;
    assign io_bus.busy       = r_busy;
    assign io_bus.state_dbg  = r_state;
endmodule

// File: tb/tb_catena_power_boot_sequencer.sv
// Directed bench for the power/boot sequencer. A timestamp-based reference model is checked
// against the DUT on every cycle, and literal expectations at the named edges pin that model.
module tb_catena_power_boot_sequencer;
    localparam int N  = 3;
    localparam int RD = 4;
    localparam int LC = 3;
    localparam int BD = 5;

    localparam int P_WAIT = 0, P_UP = 1, P_RUN = 2, P_DOWN = 3, P_BW = 4, P_BOOT = 5, P_OFF = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    catena_power_boot_sequencer_if #(.N_RAILS(N)) bus_if ();

    catena_power_boot_sequencer #(
        .N_RAILS(N), .RAIL_DELAY(RD), .LOCK_CYCLES(LC), .BOOT_DELAY(BD)
    ) dut (
        .i_clk_48mhz(clk),
        .i_reset(rst),
        .io_bus(bus_if.slave)
    );

    always #5 clk = ~clk;

    // Reference model: each phase is tracked by the edges spent in it, and rails follow by division.
    int         m_state, m_t, m_lock_run, m_up, m_from, m_edges;
    bit         m_off, m_valid;
    logic [1:0] m_img;
    logic       m_core_reset, m_wb_s1, m_wb_s0, m_wb_boot;

    initial m_valid = 1'b0;

    task automatic m_enter(input int s);
        m_state = s;
        m_t     = 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_state = P_WAIT; m_t = 0; m_lock_run = 0; m_up = 0; m_from = 0;
            m_off = 1'b0; m_img = 2'b00; m_core_reset = 1'b1;
            m_wb_s1 = 1'b0; m_wb_s0 = 1'b0; m_wb_boot = 1'b0;
            m_edges = 0; m_valid = 1'b1;
        end else begin
            m_edges++;
            m_t++;
            case (m_state)
                P_WAIT: begin
                    m_lock_run = bus_if.pll_lock ? m_lock_run + 1 : 0;
                    if (m_lock_run == LC) begin m_up = 0; m_enter(P_UP); end
                end
                P_UP: begin
                    if (!bus_if.pll_lock || bus_if.shutdown_req) begin
                        m_off = bus_if.shutdown_req; m_from = m_up; m_enter(P_DOWN);
                    end else begin
                        m_up = m_t / RD;
                        if (m_up == N) begin m_core_reset = 1'b0; m_enter(P_RUN); end
                    end
                end
                P_RUN: begin
                    if (!bus_if.pll_lock || bus_if.shutdown_req) begin
                        m_core_reset = 1'b1; m_off = bus_if.shutdown_req; m_from = N; m_enter(P_DOWN);
                    end else if (bus_if.boot_req) begin
                        m_img = bus_if.boot_image; m_enter(P_BW);
                    end
                end
                P_BW: begin
                    if (!bus_if.pll_lock) begin
                        m_core_reset = 1'b1; m_from = N; m_enter(P_DOWN);
                    end else if (m_t == BD) begin
                        m_wb_s1 = m_img[1]; m_wb_s0 = m_img[0]; m_enter(P_BOOT);
                    end
                end
                P_BOOT: m_wb_boot = 1'b1;
                P_DOWN: begin
                    m_up = m_from - m_t / RD;
                    if (m_up < 0) m_up = 0;
                    if (m_t == ((m_from > 0) ? m_from : 1) * RD) begin
                        m_lock_run = 0;
                        m_enter(m_off ? P_OFF : P_WAIT);
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model rail_en", 32'(bus_if.rail_en), 32'((1 << m_up) - 1));
            chk("model core_reset", 32'(bus_if.core_reset), 32'(m_core_reset));
            chk("model wb_s1", 32'(bus_if.wb_s1), 32'(m_wb_s1));
            chk("model wb_s0", 32'(bus_if.wb_s0), 32'(m_wb_s0));
            chk("model wb_boot", 32'(bus_if.wb_boot), 32'(m_wb_boot));
            chk("model busy", 32'(bus_if.busy), 32'(m_state != P_RUN));
            chk("model state_dbg", 32'(bus_if.state_dbg), 32'(m_state));
        end
    end

    task automatic do_reset(input logic lock_after);
        @(negedge clk);
        rst = 1'b1;
        bus_if.pll_lock = 1'b0; bus_if.boot_req = 1'b0;
        bus_if.boot_image = 2'b00; bus_if.shutdown_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_if.pll_lock = lock_after;
    endtask

    // Returns at the negedge just after edge k; inputs set afterwards apply to edge k+1.
    task automatic to_edge(input int k);
        int guard;
        guard = 0;
        while (m_edges < k + 1) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                total++; bad++;
                $display("FAIL to_edge timeout actual=%0d required=%0d", m_edges, k + 1);
                return;
            end
        end
    endtask

    initial begin
        // Power-up, lock loss in RUN, re-ramp, then warmboot.
        do_reset(1'b1);
        chk("reset core_reset", 32'(bus_if.core_reset), 32'd1);
        chk("reset busy", 32'(bus_if.busy), 32'd1);
        to_edge(1);  chk("pu state@1", 32'(bus_if.state_dbg), 32'd0);
        to_edge(2);  chk("pu state@2", 32'(bus_if.state_dbg), 32'd1);
        to_edge(5);  chk("pu rail@5", 32'(bus_if.rail_en), 32'b000);
        to_edge(6);  chk("pu rail@6", 32'(bus_if.rail_en), 32'b001);
        to_edge(10); chk("pu rail@10", 32'(bus_if.rail_en), 32'b011);
        to_edge(13); chk("pu core_reset@13", 32'(bus_if.core_reset), 32'd1);
        to_edge(14);
        chk("pu rail@14", 32'(bus_if.rail_en), 32'b111);
        chk("pu core_reset@14", 32'(bus_if.core_reset), 32'd0);
        chk("pu busy@14", 32'(bus_if.busy), 32'd0);
        bus_if.pll_lock = 1'b0;
        to_edge(15);
        chk("ll core_reset@15", 32'(bus_if.core_reset), 32'd1);
        chk("ll state@15", 32'(bus_if.state_dbg), 32'd3);
        to_edge(19); chk("ll rail@19", 32'(bus_if.rail_en), 32'b011);
        to_edge(23); chk("ll rail@23", 32'(bus_if.rail_en), 32'b001);
        bus_if.pll_lock = 1'b1;
        to_edge(27);
        chk("ll rail@27", 32'(bus_if.rail_en), 32'b000);
        chk("ll state@27", 32'(bus_if.state_dbg), 32'd0);
        to_edge(30); chk("rr state@30", 32'(bus_if.state_dbg), 32'd1);
        to_edge(42);
        chk("rr rail@42", 32'(bus_if.rail_en), 32'b111);
        chk("rr core_reset@42", 32'(bus_if.core_reset), 32'd0);
        bus_if.boot_req = 1'b1; bus_if.boot_image = 2'b10;
        to_edge(43);
        bus_if.boot_req = 1'b0; bus_if.boot_image = 2'b01;
        chk("wb state@43", 32'(bus_if.state_dbg), 32'd4);
        to_edge(47);
        chk("wb state@47", 32'(bus_if.state_dbg), 32'd4);
        chk("wb s1@47", 32'(bus_if.wb_s1), 32'd0);
        to_edge(48);
        chk("wb s1@48", 32'(bus_if.wb_s1), 32'd1);
        chk("wb s0@48", 32'(bus_if.wb_s0), 32'd0);
        chk("wb boot@48", 32'(bus_if.wb_boot), 32'd0);
        to_edge(49);
        chk("wb boot@49", 32'(bus_if.wb_boot), 32'd1);
        bus_if.pll_lock = 1'b0; bus_if.shutdown_req = 1'b1;
        to_edge(60);
        chk("wb hold rail", 32'(bus_if.rail_en), 32'b111);
        chk("wb hold core_reset", 32'(bus_if.core_reset), 32'd0);
        chk("wb hold state", 32'(bus_if.state_dbg), 32'd5);

        // Lock glitch, boot_req dropped outside RUN, then reset in the middle of ramp-down.
        do_reset(1'b1);
        to_edge(1); bus_if.pll_lock = 1'b0;
        to_edge(2); bus_if.pll_lock = 1'b1;
        to_edge(4); chk("lg state@4", 32'(bus_if.state_dbg), 32'd0);
        to_edge(5); chk("lg state@5", 32'(bus_if.state_dbg), 32'd1);
        bus_if.boot_req = 1'b1;
        to_edge(6); bus_if.boot_req = 1'b0;
        to_edge(8); chk("lg rail@8", 32'(bus_if.rail_en), 32'b000);
        to_edge(9); chk("lg rail@9", 32'(bus_if.rail_en), 32'b001);
        to_edge(17);
        chk("lg rail@17", 32'(bus_if.rail_en), 32'b111);
        chk("lg wb_s1@17", 32'(bus_if.wb_s1), 32'd0);
        bus_if.pll_lock = 1'b0;
        to_edge(22);
        chk("rd rail@22", 32'(bus_if.rail_en), 32'b011);
        rst = 1'b1;
        @(negedge clk);
        chk("rd rst rail", 32'(bus_if.rail_en), 32'b000);
        chk("rd rst core_reset", 32'(bus_if.core_reset), 32'd1);
        chk("rd rst state", 32'(bus_if.state_dbg), 32'd0);
        chk("rd rst wb", 32'({bus_if.wb_s1, bus_if.wb_s0, bus_if.wb_boot}), 32'd0);

        // Simultaneous shutdown and boot request in RUN.
        do_reset(1'b1);
        to_edge(14);
        bus_if.shutdown_req = 1'b1; bus_if.boot_req = 1'b1; bus_if.boot_image = 2'b11;
        to_edge(15);
        bus_if.shutdown_req = 1'b0; bus_if.boot_req = 1'b0;
        chk("sd state@15", 32'(bus_if.state_dbg), 32'd3);
        chk("sd core_reset@15", 32'(bus_if.core_reset), 32'd1);
        to_edge(27);
        chk("sd rail@27", 32'(bus_if.rail_en), 32'b000);
        chk("sd state@27", 32'(bus_if.state_dbg), 32'd6);
        bus_if.boot_req = 1'b1;
        to_edge(28); bus_if.boot_req = 1'b0; bus_if.pll_lock = 1'b0;
        to_edge(31); bus_if.pll_lock = 1'b1;
        to_edge(40);
        chk("sd off state", 32'(bus_if.state_dbg), 32'd6);
        chk("sd off wb", 32'({bus_if.wb_s1, bus_if.wb_s0, bus_if.wb_boot}), 32'd0);
        chk("sd off core_reset", 32'(bus_if.core_reset), 32'd1);

        // Shutdown part-way through the ramp-up.
        do_reset(1'b1);
        to_edge(7); bus_if.shutdown_req = 1'b1;
        to_edge(8); bus_if.shutdown_req = 1'b0;
        chk("su state@8", 32'(bus_if.state_dbg), 32'd3);
        to_edge(11); chk("su rail@11", 32'(bus_if.rail_en), 32'b001);
        to_edge(12);
        chk("su rail@12", 32'(bus_if.rail_en), 32'b000);
        chk("su state@12", 32'(bus_if.state_dbg), 32'd6);
        to_edge(16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
